cic_interp_pc: RTL and testbench
================================

// Module: cic_interp_pc
// PURPOSE
//  N-stage CIC interpolator, the transmit-side counterpart of the CIC decimator CIC_pc.
//  Takes one low-rate sample per R clocks (val_in strobe) and runs it through N combs at
//  the low rate. The result is zero-stuffed by R, and N integrators run every clock.
//  Produces one high-rate sample per clock (val_out) for the DAC/upconversion path.
// PARAMETERS
//  Win  16    input sample width (signed)
//  Wg   22    growth bits; must be >= ceil(log2(R^(N-1))) (22 for R=2000, N=3)
//  N    3     number of comb and integrator stages (1..6)
//  R    2000  interpolation factor (>=2); nominal val_in period in clocks
// PORTS
//  clk      in   1        system clock, rising edge
//  rst      in   1        asynchronous active-high reset
//  val_in   in   1        one-cycle strobe; i_data valid
//  i_data   in   Win      signed low-rate input sample
//  val_out  out  1        o_data valid (high every clock once running)
//  o_data   out  Win+Wg   signed high-rate output sample
//  err      out  1        sticky protocol error (val_in period != R)
// BEHAVIOUR
//  Reset (async, rst=1): every register cleared.
//   - Outputs: val_out=0, o_data=0, err=0.
//   - Internal state: comb delays, integrators, phase counter, run flag = 0.
//   - Reset mid-stream discards all state; restart needs a fresh val_in.
//  Arithmetic: all internal paths are Wo=Win+Wg bits two's complement.
//   - Input is sign-extended to Wo.
//   - Add/sub wrap modulo 2^Wo; no saturation is allowed, because CIC correctness relies on wrap.
//  Comb section (updates only on accepted samples):
//   - d0 = sext(i_data); dk = d(k-1) - zk; zk <= d(k-1), for k=1..N.
//   - dN is registered into up_reg; up_vld=1 for exactly one clock.
//  Zero-stuffing: u = up_vld ? up_reg : 0.
//  Integrator section (once run=1, every clock):
//   - I1 <= I1 + u; Ik <= Ik + I(k-1); o_data = IN (registered).
//  Latency: the first accepted val_in is sampled at edge e0.
//   - The impulse reaches o_data at edge e0+N+1.
//   - val_out rises at that same edge (run flag delayed N+1 clocks through a shift register).
//   - val_out then stays 1 every clock until reset.
//  Phase counter ph (0..R-1):
//   - Cleared to 0 on each accepted sample; increments otherwise once run=1.
//   - val_in with run=0: accepted, and sets run=1.
//   - val_in at ph==R-1: nominal case, accepted.
//   - Early val_in (ph<R-1): still accepted and ph restarts; err<=1.
//   - Missing val_in (ph==R-1 and val_in=0): a zero sample is inserted (combs update with
//     d0=0), ph restarts, and err<=1.
//  err is sticky until rst.
//  DC gain is R^(N-1): a constant input x settles to x*R^(N-1) after N*R clocks.
// STRUCTURE
//  Shared header cic_defs.vh:
//   - CIC default parameters (Win, Wg, N, R).
//   - Macro for Wo.
//   - Growth-check constant function clog2.
//  Sub-module cic_int_stage (Wo-bit accumulator with enable, async reset).
//   - Instantiated N times by a generate loop.
//  Combs, phase control and the valid pipeline stay in the top level.
// TESTING
//  Bench is file-driven like the decimator bench.
//   - Drives val_in every R clocks from s_CICI_in.txt.
//   - On val_out, compares o_data against s_CICI_out.txt (%b, 38 bits).
//   - Counts errors and checked samples.
//  1 Impulse: i_data=1 once, then 0s.
//    -> o_data on successive val_out clocks = 0.., then 1,3,6,10,15 (triangular).
//    -> The first 1 appears N+1=4 clocks after the val_in edge.
//  2 DC step: i_data=1 held.
//    -> o_data settles to 4,000,000 after 3*2000 clocks and stays constant.
//  3 Full scale: i_data=-32768 held.
//    -> Settles to -131,072,000,000; i_data=32767 settles to 131,068,000,000.
//    -> No overflow, err=0.
//  4 Protocol errors:
//    -> val_in at ph=500: sample accepted, err=1.
//    -> val_in omitted for one period: a zero is inserted at ph=R-1, err=1.
//  5 Reset mid-stream: rst pulsed 3 clocks mid-ramp.
//    -> val_out=0, o_data=0 immediately.
//    -> After the next val_in, output matches the model restarted from zero state.
//  6 Random stimulus: 200 random Win-bit samples vs MATLAB fixed-point model -> 0 errors.

Source files
------------

// File: rtl/cic_interp_pc_pkg.sv
// rtl/cic_interp_pc_pkg.sv - default CIC interpolator parameters and growth-check helpers
package cic_interp_pc_pkg;

   localparam int WIN_DEF = 16;
   localparam int WG_DEF  = 22;
   localparam int N_DEF   = 3;
   localparam int R_DEF   = 2000;

   function automatic int clog2(input longint v);
      for (int i = 0; i < 63; i++) begin
         if ((64'sd1 <<< i) >= v) return i;
      end
      return 63;
   endfunction

   // Minimum growth bits for an N-stage interpolator: ceil(log2(R^(N-1)))
   function automatic int growth_bits(input int r, input int n);
      longint p;
      p = 1;
      for (int i = 1; i < n; i++) p = p * longint'(r);
      return clog2(p);
   endfunction

endpackage

// File: rtl/cic_interp_pc_int_stage.sv
// rtl/cic_interp_pc_int_stage.sv - wrapping W-bit integrator with enable
module cic_interp_pc_int_stage #(
   parameter int W = 38
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                en,
   input  logic signed [W-1:0] din,
   output logic signed [W-1:0] acc
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc <= '0;
      end else if (en) begin
         acc <= acc + din;
      end
   end

endmodule

// File: rtl/cic_interp_pc.sv
// rtl/cic_interp_pc.sv - N-stage CIC interpolator: low-rate combs, zero-stuff, high-rate integrators
module cic_interp_pc
   import cic_interp_pc_pkg::*;
#(
   parameter int Win = WIN_DEF,
   parameter int Wg  = WG_DEF,
   parameter int N   = N_DEF,
   parameter int R   = R_DEF
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     val_in,
   input  logic signed [Win-1:0]    i_data,
   output logic                     val_out,
   output logic signed [Win+Wg-1:0] o_data,
   output logic                     err
);

   localparam int Wo  = Win + Wg;
   localparam int PHW = $clog2(R);

   if (Wg < growth_bits(R, N)) begin : g_growth_check
      $error("cic_interp_pc: Wg too small for R^(N-1)");
   end

   logic signed [Wo-1:0] z [N];
   logic signed [Wo-1:0] d [N+1];
   logic signed [Wo-1:0] up_reg;
   logic                 up_vld;
   logic signed [Wo-1:0] u;
   logic signed [Wo-1:0] integ [N];
   logic [PHW-1:0]       ph;
   logic                 run;
   logic [N:0]           vshift;
   logic                 ph_last;
   logic                 accept;

   assign ph_last = (ph == PHW'(R - 1));
   // A missing strobe at the end of a period still clocks the combs, with a zero sample
   assign accept  = val_in | (run & ph_last);

   always_comb begin
      d[0] = val_in ? {{Wg{i_data[Win-1]}}, i_data} : '0;
      for (int k = 1; k <= N; k++) begin
         d[k] = d[k-1] - z[k-1];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < N; k++) z[k] <= '0;
         up_reg <= '0;
         up_vld <= 1'b0;
         ph     <= '0;
         run    <= 1'b0;
         err    <= 1'b0;
         vshift <= '0;
         o_data <= '0;
      end else begin
         if (accept) begin
            for (int k = 0; k < N; k++) z[k] <= d[k];
            up_reg <= d[N];
         end
         up_vld <= accept;
         run    <= run | val_in;
         if (accept)   ph <= '0;
         else if (run) ph <= ph + PHW'(1);
         if (run && (val_in ? !ph_last : ph_last)) err <= 1'b1;
         vshift <= {vshift[N-1:0], run};
         o_data <= integ[N-1];
      end
   end

   assign u       = up_vld ? up_reg : '0;
   assign val_out = vshift[N];

   for (genvar k = 0; k < N; k++) begin : g_int
      logic signed [Wo-1:0] stage_in;
      if (k == 0) begin : g_first
         assign stage_in = u;
      end else begin : g_next
         assign stage_in = integ[k-1];
      end
      cic_interp_pc_int_stage #(.W(Wo)) u_stage (
         .clk (clk),
         .rst (rst),
         .en  (run),
         .din (stage_in),
         .acc (integ[k])
      );
   end

endmodule

// File: tb/tb_cic_interp_pc.sv
// tb/tb_cic_interp_pc.sv - directed self-checking bench for cic_interp_pc (Win=16, Wg=22, N=3, R=2000)
module tb_cic_interp_pc;

   localparam int R = 2000;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               val_in = 1'b0;
   logic signed [15:0] i_data = '0;
   logic               val_out;
   logic signed [37:0] o_data;
   logic               err;

   int n_cmp = 0;
   int n_bad = 0;
   logic signed [37:0] exp_v;

   cic_interp_pc dut (
      .clk     (clk),
      .rst     (rst),
      .val_in  (val_in),
      .i_data  (i_data),
      .val_out (val_out),
      .o_data  (o_data),
      .err     (err)
   );

   always #5 clk = ~clk;

   task automatic do_reset;
      rst = 1'b1; val_in = 1'b0; i_data = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic pulse(input int x);
      val_in = 1'b1; i_data = 16'(x);
      @(posedge clk); #1;
      val_in = 1'b0; i_data = '0;
   endtask

   task automatic drive_periods(input int x, input int n);
      for (int i = 0; i < n; i++) begin
         pulse(x);
         repeat (R - 1) @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset;
      rst = 1'b1; val_in = 1'b0; i_data = '0;
      repeat (2) @(posedge clk);
      #1;
      n_cmp++;
      if (val_out !== 1'b0 || o_data !== '0 || err !== 1'b0) begin
         n_bad++;
         $display("FAIL reset: val_out=%b o_data=%0d err=%b, need 0/0/0", val_out, o_data, err);
      end
      rst = 1'b0;
   endtask

   task automatic test_impulse;
      do_reset();
      pulse(1);
      n_cmp++;
      if (val_out !== 1'b0 || o_data !== '0) begin
         n_bad++;
         $display("FAIL impulse_e0: val_out=%b o_data=%0d, need 0/0", val_out, o_data);
      end
      for (int k = 1; k <= 8; k++) begin
         @(posedge clk); #1;
         exp_v = (k < 4) ? 38'sd0 : 38'((k - 3) * (k - 2) / 2);
         n_cmp++;
         if (val_out !== (k >= 4) || o_data !== exp_v) begin
            n_bad++;
            $display("FAIL impulse_k%0d: val_out=%b o_data=%0d, need %b/%0d", k, val_out, o_data, k >= 4, exp_v);
         end
      end
      n_cmp++;
      if (err !== 1'b0) begin
         n_bad++;
         $display("FAIL impulse_err: err=%b, need 0", err);
      end
   endtask

   task automatic test_dc_step;
      do_reset();
      drive_periods(1, 4);
      n_cmp++;
      if (o_data !== 38'sd4000000 || val_out !== 1'b1 || err !== 1'b0) begin
         n_bad++;
         $display("FAIL dc_settle: o_data=%0d val_out=%b err=%b, need 4000000/1/0", o_data, val_out, err);
      end
      drive_periods(1, 1);
      n_cmp++;
      if (o_data !== 38'sd4000000) begin
         n_bad++;
         $display("FAIL dc_hold: o_data=%0d, need 4000000", o_data);
      end
   endtask

   task automatic test_full_scale;
      do_reset();
      drive_periods(-32768, 4);
      exp_v = -38'sd131072000000;
      n_cmp++;
      if (o_data !== exp_v) begin
         n_bad++;
         $display("FAIL full_neg: o_data=%0d, need %0d", o_data, exp_v);
      end
      drive_periods(32767, 4);
      exp_v = 38'sd131068000000;
      n_cmp++;
      if (o_data !== exp_v || err !== 1'b0) begin
         n_bad++;
         $display("FAIL full_pos: o_data=%0d err=%b, need %0d/0", o_data, err, exp_v);
      end
   endtask

   task automatic test_early;
      do_reset();
      drive_periods(1, 2);
      pulse(1);
      repeat (500) @(posedge clk);
      #1;
      n_cmp++;
      if (err !== 1'b0) begin
         n_bad++;
         $display("FAIL early_before: err=%b, need 0", err);
      end
      pulse(1);
      n_cmp++;
      if (err !== 1'b1) begin
         n_bad++;
         $display("FAIL early_after: err=%b, need 1", err);
      end
      repeat (R - 1) @(posedge clk);
      #1;
      drive_periods(1, 1);
      n_cmp++;
      if (err !== 1'b1) begin
         n_bad++;
         $display("FAIL early_sticky: err=%b, need 1", err);
      end
   endtask

   task automatic test_missing;
      do_reset();
      pulse(1);
      repeat (R - 1) @(posedge clk);
      #1;
      n_cmp++;
      if (err !== 1'b0) begin
         n_bad++;
         $display("FAIL missing_before: err=%b, need 0", err);
      end
      @(posedge clk); #1;
      n_cmp++;
      if (err !== 1'b1) begin
         n_bad++;
         $display("FAIL missing_err: err=%b, need 1", err);
      end
      repeat (3) @(posedge clk);
      #1;
      n_cmp++;
      if (o_data !== 38'sd2001000) begin
         n_bad++;
         $display("FAIL missing_peak: o_data=%0d, need 2001000", o_data);
      end
      repeat (4 * R) @(posedge clk);
      #1;
      n_cmp++;
      if (o_data !== '0 || val_out !== 1'b1) begin
         n_bad++;
         $display("FAIL missing_tail: o_data=%0d val_out=%b, need 0/1", o_data, val_out);
      end
   endtask

   task automatic test_reset_mid;
      do_reset();
      drive_periods(1, 1);
      pulse(1);
      repeat (500) @(posedge clk);
      #3;
      n_cmp++;
      if (err !== 1'b0 || val_out !== 1'b1) begin
         n_bad++;
         $display("FAIL mid_before: err=%b val_out=%b, need 0/1", err, val_out);
      end
      rst = 1'b1;
      #1;
      n_cmp++;
      if (val_out !== 1'b0 || o_data !== '0 || err !== 1'b0) begin
         n_bad++;
         $display("FAIL mid_async: val_out=%b o_data=%0d err=%b, need 0/0/0", val_out, o_data, err);
      end
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      n_cmp++;
      if (val_out !== 1'b0 || o_data !== '0) begin
         n_bad++;
         $display("FAIL mid_idle: val_out=%b o_data=%0d, need 0/0", val_out, o_data);
      end
      pulse(1);
      for (int k = 1; k <= 6; k++) begin
         @(posedge clk); #1;
         exp_v = (k < 4) ? 38'sd0 : 38'((k - 3) * (k - 2) / 2);
         n_cmp++;
         if (val_out !== (k >= 4) || o_data !== exp_v) begin
            n_bad++;
            $display("FAIL mid_restart_k%0d: val_out=%b o_data=%0d, need %b/%0d", k, val_out, o_data, k >= 4, exp_v);
         end
      end
   endtask

   initial begin
      test_reset();
      test_impulse();
      test_dc_step();
      test_full_scale();
      test_early();
      test_missing();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
